// File: rtl/rd_ptr_gray_ctrl.sv
// rd_ptr_gray_ctrl
// Read-side pointer and flag controller for a dual-clock FIFO, all in the rclk domain.
// It keeps the binary and Gray read pointers and brings the write-domain Gray pointer
// into rclk through a flop chain. From these it derives registered empty,
// almost-empty, occupancy, read-valid and underflow outputs.
//
// Ports:
//   rclk               read-domain clock (posedge)
//   rd_srstn           synchronous active-low reset
//   rd_en              read request from the consumer
//   wr_ptr_gray_async  write pointer, Gray coded, from the wclk domain
//   read_ptr           binary read pointer (MSB = wrap bit)
//   read_addr          RAM read address (read_ptr without the wrap bit)
//   read_ptr_gray      registered Gray read pointer, for the write-domain synchroniser
//   empty              FIFO empty (registered)
//   almost_empty       occupancy <= AE_THRESH (registered)
//   rd_count           occupancy as seen in rclk, 0..2^PTR_LEN (registered)
//   rd_valid           RAM data addressed in the previous cycle is valid now
//   underflow          one-cycle pulse: rd_en while empty

module rd_ptr_gray_ctrl #(
    parameter int unsigned PTR_LEN     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 4
) (
    input  logic               rclk,
    input  logic               rd_srstn,
    input  logic               rd_en,
    input  logic [PTR_LEN:0]   wr_ptr_gray_async,
    output logic [PTR_LEN:0]   read_ptr,
    output logic [PTR_LEN-1:0] read_addr,
    output logic [PTR_LEN:0]   read_ptr_gray,
    output logic               empty,
    output logic               almost_empty,
    output logic [PTR_LEN:0]   rd_count,
    output logic               rd_valid,
    output logic               underflow
);

    localparam logic [PTR_LEN:0] AeThr = AE_THRESH[PTR_LEN:0];

    logic [PTR_LEN:0] r_sync [SYNC_STAGES];
    logic [PTR_LEN:0] r_read_ptr;
    logic [PTR_LEN:0] r_read_ptr_gray;
    logic             r_empty;
    logic             r_almost_empty;
    logic [PTR_LEN:0] r_rd_count;
    logic             r_rd_valid;
    logic             r_underflow;

    logic [PTR_LEN:0] w_wgray_s;
    logic [PTR_LEN:0] w_wbin_s;
    logic             w_rd_ready;
    logic [PTR_LEN:0] w_rd_ptr_next;
    logic [PTR_LEN:0] w_rd_gray_next;
    logic [PTR_LEN:0] w_count_next;

    assign w_wgray_s = r_sync[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_wbin_s = '0;
        for (int i = 0; i <= int'(PTR_LEN); i++) begin
            w_wbin_s[i] = ^(w_wgray_s >> i);
        end
    end

    // Registered empty gates the read, so a read never issues past the write pointer.
    assign w_rd_ready     = rd_en && !r_empty;
    assign w_rd_ptr_next  = r_read_ptr + {{PTR_LEN{1'b0}}, w_rd_ready};
    assign w_rd_gray_next = w_rd_ptr_next ^ (w_rd_ptr_next >> 1);
    // Modular subtraction handles the wrap bit; a full FIFO yields exactly 2^PTR_LEN.
    assign w_count_next   = w_wbin_s - w_rd_ptr_next;

    always_ff @(posedge rclk) begin
        if (!rd_srstn) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
            r_read_ptr      <= '0;
            r_read_ptr_gray <= '0;
            r_empty         <= 1'b1;
            r_almost_empty  <= 1'b1;
            r_rd_count      <= '0;
            r_rd_valid      <= 1'b0;
            r_underflow     <= 1'b0;
        end else begin
            r_sync[0] <= wr_ptr_gray_async;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_read_ptr      <= w_rd_ptr_next;
            r_read_ptr_gray <= w_rd_gray_next;
            // Flags come from next-state pointers so the last read sets empty on its own edge.
            r_empty         <= (w_rd_gray_next == w_wgray_s);
            r_almost_empty  <= (w_count_next <= AeThr);
            r_rd_count      <= w_count_next;
            r_rd_valid      <= w_rd_ready;
            r_underflow     <= rd_en && r_empty;
        end
    end

    assign read_ptr      = r_read_ptr;
    assign read_addr     = r_read_ptr[PTR_LEN-1:0];
    assign read_ptr_gray = r_read_ptr_gray;
    assign empty         = r_empty;
    assign almost_empty  = r_almost_empty;
    assign rd_count      = r_rd_count;
    assign rd_valid      = r_rd_valid;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_rd_ptr_gray_ctrl.sv
// tb_rd_ptr_gray_ctrl
// Directed bench for rd_ptr_gray_ctrl. Each step pushes the expected post-edge state,
// computed by an occupancy-based model, onto a scoreboard queue. After the edge it pops
// that entry and compares it with the DUT outputs. Constant checks from the test plan
// sit alongside the scoreboard comparisons.

module tb_rd_ptr_gray_ctrl;

    localparam int PL = 8;
    localparam int SS = 2;
    localparam int AE = 4;
    localparam int MOD = 1 << (PL + 1);

    logic          rclk;
    logic          rd_srstn;
    logic          rd_en;
    logic [PL:0]   wr_ptr_gray_async;
    logic [PL:0]   read_ptr;
    logic [PL-1:0] read_addr;
    logic [PL:0]   read_ptr_gray;
    logic          empty;
    logic          almost_empty;
    logic [PL:0]   rd_count;
    logic          rd_valid;
    logic          underflow;

    rd_ptr_gray_ctrl #(
        .PTR_LEN    (PL),
        .SYNC_STAGES(SS),
        .AE_THRESH  (AE)
    ) dut (
        .rclk             (rclk),
        .rd_srstn         (rd_srstn),
        .rd_en            (rd_en),
        .wr_ptr_gray_async(wr_ptr_gray_async),
        .read_ptr         (read_ptr),
        .read_addr        (read_addr),
        .read_ptr_gray    (read_ptr_gray),
        .empty            (empty),
        .almost_empty     (almost_empty),
        .rd_count         (rd_count),
        .rd_valid         (rd_valid),
        .underflow        (underflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct packed {
        logic [PL:0] ptr;
        logic [PL:0] gray;
        logic [PL:0] cnt;
        logic        emp;
        logic        ae;
        logic        vld;
        logic        uf;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Model state: occupancy derived from integer write/read positions.
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_empty = 1'b1;
    int m_pipe[SS];
    int wbin    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic srstn);
        exp_t e;
        int   nxt;
        bit   ready;
        logic [PL:0] wv;
        wv = wbin[PL:0];
        rd_en = en;
        rd_srstn = srstn;
        wr_ptr_gray_async = wv ^ (wv >> 1);
        if (!srstn) begin
            m_ptr = 0;
            m_cnt = 0;
            m_empty = 1'b1;
            for (int i = 0; i < SS; i++) m_pipe[i] = 0;
            e.ptr = '0; e.gray = '0; e.cnt = '0;
            e.emp = 1'b1; e.ae = 1'b1; e.vld = 1'b0; e.uf = 1'b0;
        end else begin
            ready = en && !m_empty;
            nxt = (m_ptr + int'(ready)) % MOD;
            e.uf = en && m_empty;
            e.vld = ready;
            m_cnt = (m_pipe[SS-1] - nxt + MOD) % MOD;
            m_empty = (m_cnt == 0);
            m_ptr = nxt;
            e.ptr = m_ptr[PL:0];
            e.gray = e.ptr ^ (e.ptr >> 1);
            e.cnt = m_cnt[PL:0];
            e.emp = m_empty;
            e.ae = (m_cnt <= AE);
            for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = wbin;
        end
        sb.push_back(e);
        @(posedge rclk);
        #1;
        e = sb.pop_front();
        check("sb_read_ptr", 32'(read_ptr), 32'(e.ptr));
        check("sb_read_addr", 32'(read_addr), 32'(e.ptr[PL-1:0]));
        check("sb_read_ptr_gray", 32'(read_ptr_gray), 32'(e.gray));
        check("sb_rd_count", 32'(rd_count), 32'(e.cnt));
        check("sb_empty", 32'(empty), 32'(e.emp));
        check("sb_almost_empty", 32'(almost_empty), 32'(e.ae));
        check("sb_rd_valid", 32'(rd_valid), 32'(e.vld));
        check("sb_underflow", 32'(underflow), 32'(e.uf));
    endtask

    initial begin
        int exp_ptr  [5] = '{1, 2, 3, 4, 5};
        int exp_gray [5] = '{1, 3, 2, 6, 7};
        int exp_cnt  [5] = '{4, 3, 2, 1, 0};
        int prev_ptr;
        int prev_gray;
        bit saw_wrap;

        for (int i = 0; i < SS; i++) m_pipe[i] = 0;
        rd_en = 1'b0;
        rd_srstn = 1'b0;
        wr_ptr_gray_async = '0;

        // Test 1: reset with rd_en high.
        wbin = 0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_read_ptr", 32'(read_ptr), 0);
        check("rst_read_ptr_gray", 32'(read_ptr_gray), 0);
        check("rst_rd_count", 32'(rd_count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_almost_empty", 32'(almost_empty), 1);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_underflow", 32'(underflow), 0);

        // Test 2: write pointer jumps to 5; visible after exactly three edges.
        wbin = 5;
        step(1'b0, 1'b1);
        check("arr_e1_empty", 32'(empty), 1);
        check("arr_e1_count", 32'(rd_count), 0);
        step(1'b0, 1'b1);
        check("arr_e2_empty", 32'(empty), 1);
        check("arr_e2_count", 32'(rd_count), 0);
        step(1'b0, 1'b1);
        check("arr_e3_empty", 32'(empty), 0);
        check("arr_e3_count", 32'(rd_count), 5);
        check("arr_e3_almost_empty", 32'(almost_empty), 0);

        // Test 3: drain five entries, then one underflowing read.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            check("drain_read_ptr", 32'(read_ptr), 32'(exp_ptr[i]));
            check("drain_gray", 32'(read_ptr_gray), 32'(exp_gray[i]));
            check("drain_count", 32'(rd_count), 32'(exp_cnt[i]));
            check("drain_almost_empty", 32'(almost_empty), 1);
            check("drain_empty", 32'(empty), (i == 4) ? 1 : 0);
            check("drain_rd_valid", 32'(rd_valid), 1);
            check("drain_underflow", 32'(underflow), 0);
        end
        step(1'b1, 1'b1);
        check("uf_pulse", 32'(underflow), 1);
        check("uf_read_ptr_hold", 32'(read_ptr), 5);
        check("uf_rd_valid", 32'(rd_valid), 0);
        step(1'b0, 1'b1);
        check("uf_not_sticky", 32'(underflow), 0);

        // Test 4: write and read one per cycle through the pointer wrap.
        saw_wrap = 1'b0;
        prev_ptr = -1;
        prev_gray = -1;
        for (int i = 0; i < 520; i++) begin
            wbin = (wbin + 1) % MOD;
            step(1'b1, 1'b1);
            if (i >= 4) begin
                check("wrap_empty", 32'(empty), 0);
                check("wrap_count", 32'(rd_count), 1);
            end
            if (prev_ptr == 511 && prev_gray == 9'h100 && read_ptr == 9'd0 &&
                read_ptr_gray == 9'h000) begin
                saw_wrap = 1'b1;
            end
            prev_ptr = int'(read_ptr);
            prev_gray = int'(read_ptr_gray);
        end
        check("wrap_seen", 32'(saw_wrap), 1);

        // Test 5: full FIFO with read_ptr held at 0.
        wbin = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 1; k <= 256; k++) begin
            wbin = k;
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("full_count", 32'(rd_count), 256);
        check("full_empty", 32'(empty), 0);
        check("full_almost_empty", 32'(almost_empty), 0);
        step(1'b1, 1'b1);
        check("full_read_count", 32'(rd_count), 255);
        check("full_read_ptr", 32'(read_ptr), 1);

        // Test 6: reset during a drain at rd_count=3.
        wbin = 0;
        step(1'b0, 1'b0);
        wbin = 5;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("mid_pre_count", 32'(rd_count), 3);
        step(1'b1, 1'b0);
        check("mid_rst_read_ptr", 32'(read_ptr), 0);
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_rd_valid", 32'(rd_valid), 0);
        check("mid_rst_underflow", 32'(underflow), 0);
        step(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rd_ptr_gray_ctrl.md
Name: rd_ptr_gray_ctrl

Overview:
Parametrised read-side controller for the dual-clock FIFO. It keeps the binary and Gray read pointers and synchronises the write-domain Gray pointer into rclk. It produces registered empty, almost-empty, occupancy count, read-valid and underflow for the read port of the FIFO RAM. It sits in the rclk domain between the FIFO memory and the downstream reader.

Parameters:
PTR_LEN, 8, address width; FIFO depth = 2^PTR_LEN; pointers are PTR_LEN+1 bits (MSB = wrap bit)
SYNC_STAGES, 2, flops in the wr-pointer synchroniser chain (legal 2..4)
AE_THRESH, 4, almost_empty asserts when occupancy <= AE_THRESH (legal 0..2^PTR_LEN-1)

Ports:
rclk  input  1  read-domain clock; all logic on posedge
rd_srstn  input  1  synchronous active-low reset
rd_en  input  1  read request from consumer
wr_ptr_gray_async  input  PTR_LEN+1  write pointer, Gray coded, from the wclk domain
read_ptr  output  PTR_LEN+1  binary read pointer
read_addr  output  PTR_LEN  RAM read address = read_ptr[PTR_LEN-1:0]
read_ptr_gray  output  PTR_LEN+1  Gray read pointer, registered, for the write-domain synchroniser
empty  output  1  FIFO empty, registered
almost_empty  output  1  occupancy <= AE_THRESH, registered
rd_count  output  PTR_LEN+1  occupancy as seen in rclk, 0..2^PTR_LEN, registered
rd_valid  output  1  RAM data at read_addr of the previous cycle is valid this cycle
underflow  output  1  one-cycle pulse: rd_en while empty

Behaviour:
- Reset: rd_srstn=0 at a posedge clears all state.
  - Sync chain, read_ptr, read_ptr_gray, rd_count, rd_valid and underflow go to 0.
  - empty and almost_empty go to 1.
  - Reset has priority over rd_en.
- rd_ready = rd_en && !empty, using the registered empty.
- Pointer advance:
  - rd_ptr_next = read_ptr + rd_ready, modulo 2^(PTR_LEN+1). Natural wrap from all-ones to 0; the MSB toggles each pass.
  - read_ptr_gray <= rd_ptr_next ^ (rd_ptr_next >> 1). This register is the only pointer that crosses domains.
- Synchroniser:
  - wr_ptr_gray_async passes through SYNC_STAGES flops.
  - The final stage is wgray_s. wbin_s is the combinational Gray-to-binary conversion of wgray_s.
- Flags, all registered from next-state values:
  - empty <= (gray(rd_ptr_next) == wgray_s).
  - rd_count <= wbin_s - rd_ptr_next, modulo 2^(PTR_LEN+1).
  - almost_empty <= (that same count <= AE_THRESH).
  - The last read drives empty=1 on the same edge the pointer reaches the write pointer. There is no extra-read window.
- Latency:
  - A write-pointer change stable before edge k is captured at edge k.
  - empty/rd_count/almost_empty reflect it after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 edges.
  - A read updates read_ptr, read_ptr_gray, empty, rd_count and almost_empty at the same edge.
- rd_valid <= rd_ready. This assumes 1-cycle synchronous RAM read latency.
- underflow <= rd_en && empty.
  - One-cycle pulse, not sticky.
  - The pointer holds and no rd_valid is issued.
- Full FIFO: rd_count = 2^PTR_LEN (wrap bits differ, lower bits equal). empty=0 and almost_empty=0.
- Simultaneous read and write-pointer update: both are applied in the next-state count. The count can stay constant and empty must not glitch.
- Illegal input: the write pointer changing by more than 1 Gray step per wclk is not supported. Behaviour is undefined and no check is made.

Test Plan:
1. Reset: rd_srstn=0 for 2 cycles with rd_en=1 -> read_ptr=0, read_ptr_gray=0, rd_count=0, empty=1, almost_empty=1, rd_valid=0, underflow=0.
2. Write arrival: drive wr_ptr_gray_async=gray(5)=9'h007, rd_en=0 -> after exactly 3 edges empty=0, rd_count=5, almost_empty=0 (AE_THRESH=4); unchanged before that.
3. Drain: rd_en=1 for 6 cycles after test 2.
   - read_ptr goes 1,2,3,4,5 and read_ptr_gray goes 1,3,2,6,7.
   - almost_empty=1 when rd_count=4.
   - empty=1 at the 5th read edge.
   - rd_valid high for 5 cycles.
   - The 6th cycle gives underflow=1 and read_ptr stays 5.
4. Wrap: step the write pointer 1 Gray step per cycle while reading continuously from read_ptr=508 -> read_ptr goes 511->0 (gray 9'h100->9'h000), no spurious empty, rd_count stays consistent.
5. Full: hold read_ptr=0 and step wr_ptr to binary 256 -> rd_count=256, empty=0, almost_empty=0. A read then gives rd_count=255.
6. Reset mid-drain: assert rd_srstn=0 with rd_en=1 and rd_count=3 -> next edge read_ptr=0, empty=1, rd_valid=0, no underflow pulse.
